// File: rtl/seq_carry_select_adder_pkg.sv
// Shared definitions for the sequential carry-select adder.
//
// Contents:
//   CSA_WIDTH / CSA_CHUNK : default operand width and bits handled per clock
//   NCHUNK                : number of slices for the default configuration
//   idx_bits()            : width of a slice index for a given slice count
//   IDX_W                 : slice index width for the default configuration
//   state_t               : controller states IDLE / ADD / DONE
//
// Optional feature macro used elsewhere in this slice: SEQ_CSA_OVERFLOW_EN.
package seq_csa_pkg;

   localparam int CSA_WIDTH = 64;
   localparam int CSA_CHUNK = 16;
   localparam int NCHUNK    = CSA_WIDTH / CSA_CHUNK;

   // A single-slice configuration still needs a one-bit index so that
   // the index register never collapses to zero width.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_bits(NCHUNK);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_carry_select_adder_if.sv
// Handshake bundle for the sequential carry-select adder.
//
// Signals:
//   in_valid / in_ready   : operand handshake (producer -> adder)
//   a, b, cin             : operands and carry-in, sampled on the accepting edge
//   out_valid / out_ready : result handshake (adder -> consumer)
//   sum, cout             : a + b + cin modulo 2^WIDTH, and the carry out
//   overflow              : signed overflow, only when SEQ_CSA_OVERFLOW_EN is defined
//
// Modports: master = producer/consumer side, slave = the adder.
interface seq_carry_select_adder_if #(
   parameter int WIDTH = 64
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SEQ_CSA_OVERFLOW_EN
   logic             overflow;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
`endif

endinterface

// File: rtl/seq_carry_select_adder_csa_slice.sv
// One combinational carry-select slice.
//
// Two CHUNK-bit sums are formed in parallel, one assuming a carry-in of 0
// and one assuming 1; a 2:1 multiplexer per bit (plus one for the carry)
// picks the right pair once the real carry, sel, is known.
//
// Ports:
//   a_slice, b_slice : CHUNK-bit operand slices
//   sel              : carry into this slice
//   s                : selected CHUNK-bit sum
//   co               : selected carry out of this slice
module csa_slice #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a_slice,
   input  logic [CHUNK-1:0] b_slice,
   input  logic             sel,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   logic [CHUNK:0] s0;
   logic [CHUNK:0] s1;

   // Both speculative sums carry one extra bit so the slice carry-out
   // comes straight out of the adder.
   always_comb begin
      s0 = {1'b0, a_slice} + {1'b0, b_slice};
      s1 = {1'b0, a_slice} + {1'b0, b_slice} + (CHUNK+1)'(1);
   end

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit_mux
      assign s[i] = sel ? s1[i] : s0[i];
   end

   assign co = sel ? s1[CHUNK] : s0[CHUNK];

endmodule

// File: rtl/seq_carry_select_adder.sv
// Multi-cycle carry-select adder: WIDTH-bit operands are added one
// CHUNK-bit slice per clock, least significant slice first, with the
// slice carry held in a register between clocks.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_carry_select_adder_if.slave (operand and result handshakes)
//
// Optional feature: define SEQ_CSA_OVERFLOW_EN to add the registered
// signed-overflow output bus.overflow.
module seq_carry_select_adder
   import seq_csa_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH,
   parameter int CHUNK = CSA_CHUNK
) (
   input  logic                     clk,
   input  logic                     rst_n,
   seq_carry_select_adder_if.slave  bus
);

   localparam int N_SLICES = WIDTH / CHUNK;
   localparam int IW       = idx_bits(N_SLICES);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [IW-1:0]    idx_q, idx_d;
`ifdef SEQ_CSA_OVERFLOW_EN
   logic             ovf_q, ovf_d;
`endif

   logic [CHUNK-1:0] a_slice;
   logic [CHUNK-1:0] b_slice;
   logic [CHUNK-1:0] slice_s;
   logic             slice_co;
   logic             accept;
   logic             last_slice;

   assign accept     = bus.in_valid && (state_q == IDLE);
   assign last_slice = (idx_q == IW'(N_SLICES - 1));

   // Feed the slice currently addressed by the index to the select adder.
   always_comb begin
      a_slice = a_q[int'(idx_q)*CHUNK +: CHUNK];
      b_slice = b_q[int'(idx_q)*CHUNK +: CHUNK];
   end

   csa_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a_slice (a_slice),
      .b_slice (b_slice),
      .sel     (carry_q),
      .s       (slice_s),
      .co      (slice_co)
   );

   // State register plus every datapath register; reset throws away any
   // operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
`ifdef SEQ_CSA_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
`ifdef SEQ_CSA_OVERFLOW_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Next-state logic: DONE only leaves once the consumer takes the result,
   // so a new operation can be accepted no earlier than the following cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)        state_d = ADD;
         ADD:     if (last_slice)    state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Datapath next values: latch operands on accept, then write one sum
   // slice per clock and pass its carry on to the next slice.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
`ifdef SEQ_CSA_OVERFLOW_EN
      ovf_d   = ovf_q;
`endif
      if (accept) begin
         a_d     = bus.a;
         b_d     = bus.b;
         carry_d = bus.cin;
         idx_d   = '0;
      end else if (state_q == ADD) begin
         sum_d[int'(idx_q)*CHUNK +: CHUNK] = slice_s;
         carry_d = slice_co;
         idx_d   = last_slice ? '0 : idx_q + 1'b1;
         if (last_slice) begin
            cout_d = slice_co;
`ifdef SEQ_CSA_OVERFLOW_EN
            // Carry into the MSB is recovered from the MSB sum bit itself.
            ovf_d  = (a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ slice_s[CHUNK-1]) ^ slice_co;
`endif
         end
      end
   end

   // Handshake outputs are decoded from the state; results come straight
   // from their registers.
   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.sum       = sum_q;
      bus.cout      = cout_q;
`ifdef SEQ_CSA_OVERFLOW_EN
      bus.overflow  = ovf_q;
`endif
   end

endmodule

// File: tb/tb_seq_carry_select_adder.sv
// Self-checking bench for seq_carry_select_adder: directed corner cases
// plus randomized operands compared with a plain-arithmetic reference.
// Honours SEQ_CSA_OVERFLOW_EN when checking the overflow output.
module tb_seq_carry_select_adder;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   seq_carry_select_adder_if #(.WIDTH(64)) bus ();

   seq_carry_select_adder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: full-width arithmetic sum with the carry as bit 64.
   function automatic logic [64:0] refAdd(input logic [63:0] x, input logic [63:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + 65'(c);
   endfunction

   // Signed overflow: operands agree in sign but the result does not.
   function automatic logic refOvf(input logic [63:0] x, input logic [63:0] y, input logic [63:0] s);
      return (x[63] == y[63]) && (s[63] != x[63]);
   endfunction

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Runs one full transaction: present operands, wait for accept, then
   // measure latency, check the result, hold it for 'hold' cycles and
   // consume it. After accept the input pins carry nextA/nextB/nextCin and
   // in_valid is left at keepValid.
   task automatic applyStimulus(input logic [63:0] opA, input logic [63:0] opB, input logic opCin,
                                input int hold, input bit keepValid,
                                input logic [63:0] nextA, input logic [63:0] nextB, input logic nextCin);
      logic [64:0] expSum;
      int          waitCnt;
      int          lat;
      int          busyBad;
      int          holdBad;
      expSum = refAdd(opA, opB, opCin);
      bus.a         = opA;
      bus.b         = opB;
      bus.cin       = opCin;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      waitCnt = 0;
      while (!bus.in_ready && waitCnt < 50) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (!bus.in_ready) checkOutput("accept_timeout", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = keepValid;
      bus.a        = nextA;
      bus.b        = nextB;
      bus.cin      = nextCin;
      lat     = 0;
      busyBad = 0;
      while (!bus.out_valid && lat < 50) begin
         if (bus.in_ready) busyBad++;
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency", 64'(lat), 64'd4);
      checkOutput("sum", bus.sum, expSum[63:0]);
      checkOutput("cout", 64'(bus.cout), 64'(expSum[64]));
`ifdef SEQ_CSA_OVERFLOW_EN
      checkOutput("overflow", 64'(bus.overflow), 64'(refOvf(opA, opB, expSum[63:0])));
`endif
      holdBad = 0;
      for (int i = 0; i < hold; i++) begin
         if (bus.in_ready) busyBad++;
         @(posedge clk); #1;
         if (bus.sum !== expSum[63:0] || bus.cout !== expSum[64] || bus.out_valid !== 1'b1) holdBad++;
      end
      checkOutput("hold_stable", 64'(holdBad), 64'd0);
      checkOutput("busy_in_ready", 64'(busyBad), 64'd0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput("consumed_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("consumed_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   // Stimulus sequence.
   initial begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rc;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      rst_n         = 1'b0;

      #3;
      checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset_sum", bus.sum, 64'd0);
      checkOutput("reset_cout", 64'(bus.cout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("idle_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("idle_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("idle_sum", bus.sum, 64'd0);
      checkOutput("idle_cout", 64'(bus.cout), 64'd0);

      // Basic add, held for three cycles before consumption.
      applyStimulus(64'd5, 64'd7, 1'b0, 3, 1'b0, 64'hDEAD_BEEF_0000_1111, 64'h1234, 1'b1);

      // Carry rippling through every slice, then a signed overflow case.
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1, 1'b0, '0, '0, 1'b0);
      applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, 1'b0, '0, '0, 1'b0);

      // Carry crossing exactly one slice boundary.
      applyStimulus(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 0, 1'b0, '0, '0, 1'b0);

      // in_valid stays high through DONE with the second operands already
      // on the pins; they must only be taken after the first result is used.
      applyStimulus(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 3, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0, '0, '0, 1'b0);

      // Reset two clocks after accept must clear the outputs immediately.
      bus.a        = 64'h1111_2222_3333_4444;
      bus.b        = 64'h0000_0000_0000_0001;
      bus.cin      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("midreset_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("midreset_sum", bus.sum, 64'd0);
      checkOutput("midreset_cout", 64'(bus.cout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(64'd3, 64'd4, 1'b0, 0, 1'b0, '0, '0, 1'b0);

      // Randomized operands; every fourth pair sums to all ones so that
      // cin decides whether the carry runs the full width.
      for (int n = 0; n < 24; n++) begin
         ra = {$urandom, $urandom};
         rb = (n % 4 == 0) ? ~ra : {$urandom, $urandom};
         rc = 1'($urandom_range(0, 1));
         applyStimulus(ra, rb, rc, int'($urandom_range(0, 2)), 1'b0,
                       {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
